// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI4 read port between the fetch (ibus) and
// data (dbus) refill masters. One burst in flight at a time; the grant is
// fixed from AR acceptance until the rlast beat, then priority rotates.
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid and ready are both high. A master holds valid and payload
// stable until it sees ready. Ready never waits on the same interface's valid
// through a register.
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // fetch master
  input  logic [ADDR_WIDTH-1:0] ibus_araddr,
  input  logic [7:0]            ibus_arlen,
  input  logic [2:0]            ibus_arsize,
  input  logic [1:0]            ibus_arburst,
  input  logic                  ibus_arvalid,
  output logic                  ibus_arready,
  output logic [DATA_WIDTH-1:0] ibus_rdata,
  output logic [1:0]            ibus_rresp,
  output logic                  ibus_rlast,
  output logic                  ibus_rvalid,
  input  logic                  ibus_rready,
  // data master
  input  logic [ADDR_WIDTH-1:0] dbus_araddr,
  input  logic [7:0]            dbus_arlen,
  input  logic [2:0]            dbus_arsize,
  input  logic [1:0]            dbus_arburst,
  input  logic                  dbus_arvalid,
  output logic                  dbus_arready,
  output logic [DATA_WIDTH-1:0] dbus_rdata,
  output logic [1:0]            dbus_rresp,
  output logic                  dbus_rlast,
  output logic                  dbus_rvalid,
  input  logic                  dbus_rready,
  // memory side
  output logic [ADDR_WIDTH-1:0] mem_araddr,
  output logic [7:0]            mem_arlen,
  output logic [2:0]            mem_arsize,
  output logic [1:0]            mem_arburst,
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [1:0]            mem_rresp,
  input  logic                  mem_rlast,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  // status
  output logic                  grant_dbus,
  output logic                  busy,
  output logic                  prot_err,
  // debug visibility of the FSM and beat counter
  output logic [1:0]            dbg_state,
  output logic [7:0]            dbg_beat_ctr
);

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    ISSUE_ADDRESS = 2'd1,
    FETCH_DATA    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_prio;        // 0 = ibus preferred on a tie
  logic                  r_grant;
  logic [7:0]            r_beat_ctr;
  logic                  r_prot_err;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [2:0]            r_arsize;
  logic [1:0]            r_arburst;
  logic                  r_arvalid;

  logic w_any_req;
  logic w_win_dbus;
  logic w_owner_rready;
  logic w_rd_hs;

  assign w_any_req      = ibus_arvalid | dbus_arvalid;
  assign w_win_dbus     = dbus_arvalid & (~ibus_arvalid | r_prio);
  assign w_owner_rready = r_grant ? dbus_rready : ibus_rready;
  assign w_rd_hs        = (r_state == FETCH_DATA) & mem_rvalid & w_owner_rready;

  assign mem_araddr   = r_araddr;
  assign mem_arlen    = r_arlen;
  assign mem_arsize   = r_arsize;
  assign mem_arburst  = r_arburst;
  assign mem_arvalid  = r_arvalid;
  assign grant_dbus   = r_grant;
  assign busy         = (r_state != IDLE);
  assign prot_err     = r_prot_err;
  assign dbg_state    = r_state;
  assign dbg_beat_ctr = r_beat_ctr;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state, AR grant and R-channel routing to the current owner.
  always_comb begin
    w_next       = r_state;
    ibus_arready = 1'b0;
    dbus_arready = 1'b0;
    mem_rready   = 1'b0;
    ibus_rvalid  = 1'b0;
    ibus_rdata   = '0;
    ibus_rresp   = 2'b00;
    ibus_rlast   = 1'b0;
    dbus_rvalid  = 1'b0;
    dbus_rdata   = '0;
    dbus_rresp   = 2'b00;
    dbus_rlast   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          ibus_arready = ~w_win_dbus;
          dbus_arready = w_win_dbus;
          w_next       = ISSUE_ADDRESS;
        end
      end
      ISSUE_ADDRESS: begin
        if (mem_arready) w_next = FETCH_DATA;
      end
      FETCH_DATA: begin
        mem_rready = w_owner_rready;
        if (r_grant) begin
          dbus_rvalid = mem_rvalid;
          dbus_rdata  = mem_rdata;
          dbus_rresp  = mem_rresp;
          dbus_rlast  = mem_rlast;
        end else begin
          ibus_rvalid = mem_rvalid;
          ibus_rdata  = mem_rdata;
          ibus_rresp  = mem_rresp;
          ibus_rlast  = mem_rlast;
        end
        if (w_rd_hs && mem_rlast) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // AR capture, beat counting, priority rotation and sticky length check.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio     <= 1'b0;
      r_grant    <= 1'b0;
      r_beat_ctr <= 8'd0;
      r_prot_err <= 1'b0;
      r_araddr   <= '0;
      r_arlen    <= 8'd0;
      r_arsize   <= 3'd0;
      r_arburst  <= 2'b00;
      r_arvalid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant   <= w_win_dbus;
            r_arvalid <= 1'b1;
            r_araddr  <= w_win_dbus ? dbus_araddr  : ibus_araddr;
            r_arlen   <= w_win_dbus ? dbus_arlen   : ibus_arlen;
            r_arsize  <= w_win_dbus ? dbus_arsize  : ibus_arsize;
            r_arburst <= w_win_dbus ? dbus_arburst : ibus_arburst;
          end
        end
        ISSUE_ADDRESS: begin
          if (mem_arready) begin
            r_arvalid  <= 1'b0;
            r_beat_ctr <= 8'd0;
          end
        end
        FETCH_DATA: begin
          if (w_rd_hs) begin
            r_beat_ctr <= r_beat_ctr + 8'd1;
            // rlast must arrive exactly on beat arlen
            if (mem_rlast != (r_beat_ctr == r_arlen)) r_prot_err <= 1'b1;
            // the finishing owner drops to lowest priority
            if (mem_rlast) r_prio <= ~r_grant;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Testbench for axi_read_arbiter: table of burst records plus directed
// sequences for backpressure and reset in the middle of a burst.
module tb_axi_read_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] ibus_araddr, dbus_araddr, mem_araddr;
  logic [7:0]  ibus_arlen, dbus_arlen, mem_arlen;
  logic [2:0]  ibus_arsize, dbus_arsize, mem_arsize;
  logic [1:0]  ibus_arburst, dbus_arburst, mem_arburst;
  logic        ibus_arvalid, ibus_arready, dbus_arvalid, dbus_arready;
  logic [31:0] ibus_rdata, dbus_rdata, mem_rdata;
  logic [1:0]  ibus_rresp, dbus_rresp, mem_rresp;
  logic        ibus_rlast, dbus_rlast, mem_rlast;
  logic        ibus_rvalid, dbus_rvalid, mem_rvalid;
  logic        ibus_rready, dbus_rready, mem_rready;
  logic        mem_arvalid, mem_arready;
  logic        grant_dbus, busy, prot_err;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_beat_ctr;

  int n_checks;
  int n_errors;
  logic prot_expect;

  typedef struct {
    logic        req_i;
    logic        req_d;
    logic [31:0] addr_i;
    logic [31:0] addr_d;
    logic [7:0]  len_i;
    logic [7:0]  len_d;
    int          rlast_at;
    logic        exp_dbus;
  } vec_t;

  vec_t vecs[8];

  axi_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ibus_araddr(ibus_araddr), .ibus_arlen(ibus_arlen), .ibus_arsize(ibus_arsize),
    .ibus_arburst(ibus_arburst), .ibus_arvalid(ibus_arvalid), .ibus_arready(ibus_arready),
    .ibus_rdata(ibus_rdata), .ibus_rresp(ibus_rresp), .ibus_rlast(ibus_rlast),
    .ibus_rvalid(ibus_rvalid), .ibus_rready(ibus_rready),
    .dbus_araddr(dbus_araddr), .dbus_arlen(dbus_arlen), .dbus_arsize(dbus_arsize),
    .dbus_arburst(dbus_arburst), .dbus_arvalid(dbus_arvalid), .dbus_arready(dbus_arready),
    .dbus_rdata(dbus_rdata), .dbus_rresp(dbus_rresp), .dbus_rlast(dbus_rlast),
    .dbus_rvalid(dbus_rvalid), .dbus_rready(dbus_rready),
    .mem_araddr(mem_araddr), .mem_arlen(mem_arlen), .mem_arsize(mem_arsize),
    .mem_arburst(mem_arburst), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rlast(mem_rlast),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .grant_dbus(grant_dbus), .busy(busy), .prot_err(prot_err),
    .dbg_state(dbg_state), .dbg_beat_ctr(dbg_beat_ctr)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ri, input logic rd, input logic [31:0] ai,
                              input logic [31:0] ad, input logic [7:0] li,
                              input logic [7:0] ld, input int rl, input logic ed);
    vec_t v;
    v.req_i = ri; v.req_d = rd; v.addr_i = ai; v.addr_d = ad;
    v.len_i = li; v.len_d = ld; v.rlast_at = rl; v.exp_dbus = ed;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete burst: grant, issue with mem_arready high, then beats.
  task automatic run_burst(input vec_t v);
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;
    logic        normal;
    exp_addr = v.exp_dbus ? v.addr_d : v.addr_i;
    exp_len  = v.exp_dbus ? v.len_d : v.len_i;
    normal   = (v.rlast_at == int'(exp_len));

    step();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    ibus_arvalid = v.req_i; ibus_araddr = v.addr_i; ibus_arlen = v.len_i;
    dbus_arvalid = v.req_d; dbus_araddr = v.addr_d; dbus_arlen = v.len_d;
    mem_arready = 1'b1; ibus_rready = 1'b1; dbus_rready = 1'b1;
    @(negedge clk);
    check("grant_busy_idle", busy, 0);
    check("ibus_arready_grant", ibus_arready, !v.exp_dbus);
    check("dbus_arready_grant", dbus_arready, v.exp_dbus);

    step();
    if (v.exp_dbus) dbus_arvalid = 1'b0; else ibus_arvalid = 1'b0;
    @(negedge clk);
    check("issue_mem_arvalid", mem_arvalid, 1);
    check("issue_mem_araddr", mem_araddr, exp_addr);
    check("issue_mem_arlen", mem_arlen, exp_len);
    check("issue_mem_arsize", mem_arsize, 3'd2);
    check("issue_grant_dbus", grant_dbus, v.exp_dbus);
    check("issue_busy", busy, 1);
    check("issue_arready_both", {ibus_arready, dbus_arready}, 2'b00);

    for (int b = 0; b <= v.rlast_at; b++) begin
      step();
      mem_rvalid = 1'b1;
      mem_rdata  = exp_addr ^ b;
      mem_rresp  = b[1:0];
      mem_rlast  = (b == v.rlast_at);
      @(negedge clk);
      check("beat_rvalid_route", {ibus_rvalid, dbus_rvalid}, v.exp_dbus ? 2'b01 : 2'b10);
      check("beat_rdata", v.exp_dbus ? dbus_rdata : ibus_rdata, exp_addr ^ b);
      check("beat_rresp", v.exp_dbus ? dbus_rresp : ibus_rresp, b[1:0]);
      check("beat_rlast", v.exp_dbus ? dbus_rlast : ibus_rlast, (b == v.rlast_at));
      check("beat_other_zero", v.exp_dbus ? {ibus_rdata, ibus_rlast} : {dbus_rdata, dbus_rlast}, 0);
      check("beat_mem_rready", mem_rready, 1);
      check("beat_ctr", dbg_beat_ctr, b);
      check("beat_arready_both", {ibus_arready, dbus_arready}, 2'b00);
      if (normal) check("beat_prot_err", prot_err, prot_expect);
    end
  endtask

  initial begin
    logic [7:0] pat;
    int beat;
    n_checks = 0; n_errors = 0; prot_expect = 1'b0;

    // reset
    rst_n = 1'b0;
    ibus_araddr = '0; ibus_arlen = '0; ibus_arsize = 3'd2; ibus_arburst = 2'b01; ibus_arvalid = 1'b0;
    dbus_araddr = '0; dbus_arlen = '0; dbus_arsize = 3'd2; dbus_arburst = 2'b01; dbus_arvalid = 1'b0;
    ibus_rready = 1'b0; dbus_rready = 1'b0;
    mem_arready = 1'b0; mem_rdata = '0; mem_rresp = 2'b00; mem_rlast = 1'b0; mem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mem_arvalid", mem_arvalid, 0);
    check("rst_mem_araddr", mem_araddr, 0);
    check("rst_mem_arlen", mem_arlen, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_dbus", grant_dbus, 0);
    check("rst_prot_err", prot_err, 0);
    check("rst_arready", {ibus_arready, dbus_arready}, 2'b00);
    check("rst_rvalid", {ibus_rvalid, dbus_rvalid, mem_rready}, 3'b000);

    // burst table; priority history worked out record by record
    vecs[0] = mk(1, 1, 32'h2000, 32'h3000, 8'd3, 8'd3, 3, 0); // tie after reset -> ibus
    vecs[1] = mk(0, 1, 32'h2000, 32'h3000, 8'd3, 8'd3, 3, 1); // held dbus request
    vecs[2] = mk(1, 1, 32'h2100, 32'h3100, 8'd0, 8'd1, 0, 0); // round robin: ibus
    vecs[3] = mk(1, 1, 32'h2200, 32'h3200, 8'd2, 8'd1, 1, 1); // dbus
    vecs[4] = mk(1, 1, 32'h2300, 32'h3300, 8'd2, 8'd0, 2, 0); // ibus
    vecs[5] = mk(1, 1, 32'h2400, 32'h3400, 8'd0, 8'd0, 0, 1); // dbus
    vecs[6] = mk(1, 0, 32'h1000, 32'h0000, 8'd3, 8'd0, 3, 0); // single ibus burst
    vecs[7] = mk(0, 1, 32'h0000, 32'h6000, 8'd0, 8'd3, 2, 1); // early rlast
    for (int i = 0; i < 8; i++) run_burst(vecs[i]);

    // early rlast: back to idle, error sticky
    step();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    @(negedge clk);
    check("prot_idle_busy", busy, 0);
    check("prot_idle_state", dbg_state, 0);
    check("prot_err_set", prot_err, 1);
    step();
    @(negedge clk);
    check("prot_err_sticky", prot_err, 1);
    prot_expect = 1'b1;

    // address backpressure then dbus read backpressure
    step();
    dbus_arvalid = 1'b1; dbus_araddr = 32'h4000; dbus_arlen = 8'd3; mem_arready = 1'b0;
    @(negedge clk);
    check("bp_dbus_arready", dbus_arready, 1);
    step();
    dbus_arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_arvalid_held", mem_arvalid, 1);
      check("bp_araddr_held", mem_araddr, 32'h4000);
      check("bp_rready_low", mem_rready, 0);
      step();
    end
    mem_arready = 1'b1;
    @(negedge clk);
    check("bp_accept_arvalid", mem_arvalid, 1);
    pat = 8'b1110_0101;
    beat = 0;
    for (int c = 0; c < 8 && beat < 4; c++) begin
      step();
      mem_arready = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hB000 + beat; mem_rresp = 2'b00;
      mem_rlast = (beat == 3); dbus_rready = pat[c];
      @(negedge clk);
      check("bp_mem_rready_follow", mem_rready, pat[c]);
      check("bp_beat_ctr", dbg_beat_ctr, beat);
      check("bp_dbus_rvalid", dbus_rvalid, 1);
      check("bp_dbus_rdata", dbus_rdata, 32'hB000 + beat);
      if (pat[c]) beat++;
    end
    check("bp_all_beats", beat, 4);

    // ibus burst leaves priority pointing at dbus
    run_burst(mk(1, 0, 32'h7000, 32'h0, 8'd0, 8'd0, 0, 0));

    // dbus burst interrupted by reset on beat 1
    step();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    dbus_arvalid = 1'b1; dbus_araddr = 32'h5000; dbus_arlen = 8'd3; mem_arready = 1'b1;
    @(negedge clk);
    check("mr_dbus_arready", dbus_arready, 1);
    step();
    dbus_arvalid = 1'b0;
    @(negedge clk);
    check("mr_mem_arvalid", mem_arvalid, 1);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hC000; mem_rlast = 1'b0;
    @(negedge clk);
    check("mr_beat0", dbus_rvalid, 1);
    step();
    mem_rdata = 32'hC001; rst_n = 1'b0;
    step();
    rst_n = 1'b1; mem_rvalid = 1'b0;
    @(negedge clk);
    check("mr_busy", busy, 0);
    check("mr_grant_dbus", grant_dbus, 0);
    check("mr_mem_arvalid_low", mem_arvalid, 0);
    check("mr_prot_err", prot_err, 0);
    check("mr_rvalid", {dbus_rvalid, mem_rready}, 2'b00);
    step();
    ibus_arvalid = 1'b1; ibus_araddr = 32'h8000; ibus_arlen = 8'd1;
    dbus_arvalid = 1'b1; dbus_araddr = 32'h9000; dbus_arlen = 8'd1;
    @(negedge clk);
    check("mr_tie_ibus_arready", ibus_arready, 1);
    check("mr_tie_dbus_arready", dbus_arready, 0);
    step();
    ibus_arvalid = 1'b0;
    @(negedge clk);
    check("mr_tie_grant", grant_dbus, 0);
    check("mr_tie_araddr", mem_araddr, 32'h8000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares one AXI4 read port to memory between the instruction-fetch refill master (ibus) and the data-cache refill master (dbus). It sits between the fetch/data cache refill engines and the memory interconnect. It holds one outstanding burst at a time, grants fairly between the two masters, and locks the grant from address accept until the last read beat. Write channels are not handled by this block.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all AR channels.
- DATA_WIDTH, 32, data width of all R channels.

Ports (clock and reset first):
- clk  in  1  core clock; everything is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- ibus_araddr / ibus_arlen / ibus_arsize / ibus_arburst  in  ADDR_WIDTH / 8 / 3 / 2  fetch-master AR payload.
- ibus_arvalid  in  1;  ibus_arready  out  1.
- ibus_rdata  out  DATA_WIDTH;  ibus_rresp  out  2;  ibus_rlast  out  1;  ibus_rvalid  out  1;  ibus_rready  in  1.
- dbus_*  same set and directions as ibus_*, for the data master.
- mem_araddr / mem_arlen / mem_arsize / mem_arburst  out  same widths  registered AR payload to memory.
- mem_arvalid  out  1;  mem_arready  in  1.
- mem_rdata  in  DATA_WIDTH;  mem_rresp  in  2;  mem_rlast  in  1;  mem_rvalid  in  1;  mem_rready  out  1.
- grant_dbus  out  1  current/last owner: 0 = ibus, 1 = dbus.
- busy  out  1  asserted while state != IDLE.
- prot_err  out  1  sticky flag for a burst-length mismatch.

## Operation
- State machine: IDLE -> ISSUE_ADDRESS -> FETCH_DATA -> IDLE.
- IDLE:
  - If exactly one master has arvalid, that master wins.
  - If both do, the master named by prio_reg wins. prio_reg is 0 = ibus; its reset value is 0.
  - The winner's arready is driven combinationally high that cycle.
  - The AR payload is captured into the mem_ar* registers, grant_dbus is set to the winner, mem_arvalid goes high, and the state moves to ISSUE_ADDRESS.
  - The loser's arready stays 0; it must hold arvalid and payload (AXI rule).
- ISSUE_ADDRESS:
  - mem_ar* are held stable.
  - On mem_arready: mem_arvalid goes low, beat_ctr goes to 0, state moves to FETCH_DATA.
- FETCH_DATA, R channel passed through combinationally to the owner:
  - owner_rvalid = mem_rvalid; owner rdata/rresp/rlast = mem_r*.
  - mem_rready = owner_rready.
  - Non-owner rvalid = 0. Non-owner rdata/rresp/rlast = 0.
  - Each handshake (mem_rvalid && mem_rready) increments beat_ctr (8-bit).
  - On a handshake with mem_rlast: state moves to IDLE and prio_reg is set to the other master, so the last owner becomes lowest priority.
- Outside FETCH_DATA: mem_rready = 0 and both master rvalid = 0.
- rresp is passed through unmodified; no retry on SLVERR/DECERR.
- prot_err is set and held until reset when either occurs:
  - a handshake carries rlast while beat_ctr != mem_arlen;
  - a handshake arrives without rlast while beat_ctr == mem_arlen.
  
  The state machine still leaves FETCH_DATA only on rlast.
- Reset mid-burst:
  - state = IDLE, mem_arvalid = 0, prio_reg = 0, grant_dbus = 0, prot_err = 0.
  - The in-flight burst is abandoned; the masters reset alongside it.

## Timing
- Reset values: mem_arvalid 0, mem_ar* 0, busy 0, grant_dbus 0, prot_err 0. Combinational outputs are 0 in IDLE with no requests.
- Master AR handshake at cycle T means mem_arvalid is high from T+1. With mem_arready already high, memory accepts at T+1.
- R path has zero added latency. Earliest possible beat is T+2.
- After the rlast handshake at cycle L the state is IDLE at L+1, so a new grant is possible at L+1. Minimum gap between bursts is 2 cycles (the AR capture cycle and the issue cycle).
- Only one burst is outstanding; no AR is accepted while busy.
- arlen is used as-is: burst length is arlen+1 beats. beat_ctr wraps modulo 256, which matters only for arlen = 255.

## Test plan
- Single ibus burst: ibus_arvalid, araddr = 0x1000, arlen = 3, mem_arready = 1.
  - ibus_arready pulses 1 cycle.
  - mem_araddr = 0x1000 and mem_arvalid are high the next cycle.
  - 4 beats reach ibus, with rlast on the 4th.
  - dbus_rvalid stays 0 throughout; prot_err stays 0.
- Simultaneous requests after reset: ibus (0x2000) and dbus (0x3000) both request.
  - ibus is granted first.
  - dbus_arready stays 0 until ibus's rlast.
  - dbus is granted 1 cycle after the return to IDLE, with mem_araddr = 0x3000.
- Round-robin fairness: both masters request continuously for 4 bursts. Grant order is ibus, dbus, ibus, dbus.
- Backpressure:
  - mem_arready held low for 5 cycles: mem_arvalid and mem_araddr stay stable throughout.
  - dbus_rready toggled low during beats: mem_rready follows it, and beat_ctr advances only on handshakes.
- Protocol error: arlen = 3 but memory asserts rlast on beat 2. prot_err = 1 and stays set, and the state returns to IDLE.
- Reset mid-burst: rst_n is low for 1 cycle during beat 1 of a dbus burst.
  - Afterwards busy = 0, grant_dbus = 0, mem_arvalid = 0.
  - The next simultaneous request is granted to ibus.
